// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - alu_op_e    : 3-bit operation codes presented on alu_pipe.op
//   - alu_state_e : control FSM states (IDLE / BUSY / HOLD)
//   - FLAG_*      : bit positions inside the 4-bit flags vector {neg, zero, carry, ovf}
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

endpackage : alu_pkg

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, low WIDTH bits of product.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b and begin; must only pulse while not running
//   a, b     : operands (sampled on the start edge)
//   done     : high during the cycle of the final iteration; product is valid then
//   product  : low WIDTH bits of a*b (valid while done is high)
// One iteration is performed on every rising edge after the start edge, so the
// final (WIDTH-th) iteration lands exactly WIDTH edges after start.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             running;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;

    // The partial sum of the current iteration is exposed directly so the
    // caller can register the finished product on the same edge as the last step.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (cnt == CW'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule : alu_mul_iter

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with registered result and a valid/ready interface.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : operation handshake; a, b, op captured on accept
//   a, b, op          : operands and operation select (see alu_pkg::alu_op_e)
//   out_valid/out_ready : result handshake
//   result, flags     : registered result and {neg, zero, carry, ovf}
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Producers hold their payload stable while valid is high and not yet
// accepted; ready may depend combinationally on the consumer's ready (in_ready
// follows out_ready in HOLD) but never on the producer's valid.
//
// Single-cycle ops go IDLE/HOLD -> HOLD (one-cycle latency). MUL goes through
// BUSY for WIDTH cycles using alu_mul_iter. The FSM state is available on the
// internal signal `state` for observation.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    alu_state_e state;
    alu_state_e state_next;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic [3:0]       alu_flags;
    logic [3:0]       mul_flags;

    assign is_mul = (alu_op_e'(op) == OP_MUL);
    assign accept = in_valid && in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? ST_BUSY : ST_HOLD;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Consuming the result while accepting a new op chains directly.
                if (out_ready) begin
                    if (accept) begin
                        state_next = is_mul ? ST_BUSY : ST_HOLD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
        end
        if (state == ST_HOLD) begin
            out_valid = 1'b1;
        end
        mul_start = accept && is_mul;
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff      = a - b;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                // Same-sign operands producing an opposite-sign result.
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff;
                alu_carry = (a < b);
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SHL: alu_res = (b >= WIDTH_V) ? '0 : (a << b);
            default: alu_res = '0;
        endcase

        alu_flags             = '0;
        alu_flags[FLAG_NEG]   = alu_res[WIDTH-1];
        alu_flags[FLAG_ZERO]  = (alu_res == '0);
        alu_flags[FLAG_CARRY] = alu_carry;
        alu_flags[FLAG_OVF]   = alu_ovf;

        mul_flags             = '0;
        mul_flags[FLAG_NEG]   = mul_product[WIDTH-1];
        mul_flags[FLAG_ZERO]  = (mul_product == '0);
    end

    // ---------------- multiplier ----------------
    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // ---------------- output register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else if (accept && !is_mul) begin
            result <= alu_res;
            flags  <= alu_flags;
        end else if ((state == ST_BUSY) && mul_done) begin
            result <= mul_product;
            flags  <= mul_flags;
        end
    end

endmodule : alu_pipe

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand/op presented.
REQ-005 SHALL have port in_ready  output  1  block accepts a new operation this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  3  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port flags  output  4  {neg, zero, carry, ovf}.

Function
REQ-013 Op encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1/0), 110 SHL, 111 MUL.
REQ-014 Accept SHALL occur on a rising edge with in_valid && in_ready; a, b, op captured then; inputs ignored otherwise.
REQ-015 FSM SHALL have states IDLE, BUSY, HOLD; reset state IDLE.
REQ-016 IDLE: accept of op != MUL -> HOLD with result/flags registered (latency 1 cycle); accept of MUL -> BUSY.
REQ-017 BUSY: one shift-add iteration per cycle; after WIDTH iterations -> HOLD; out_valid first high exactly WIDTH cycles after the accept edge.
REQ-018 HOLD: out_valid=1, result/flags stable until out_ready=1; on out_ready with no accept -> IDLE; with same-cycle accept -> behaves as IDLE accept (back-to-back).
REQ-019 in_ready SHALL be (state==IDLE) || (state==HOLD && out_ready), and 0 while rst is high; in BUSY always 0.
REQ-020 MUL SHALL return the low WIDTH bits of the unsigned product.
REQ-021 SHL SHALL shift a left by b; b >= WIDTH SHALL yield 0.
REQ-022 ADD: carry = carry-out; SUB: carry = borrow (a < b unsigned); ovf = signed overflow for ADD/SUB; carry=ovf=0 for all other ops.
REQ-023 zero = (result==0); neg = result[WIDTH-1]; both for every op.

Reset
REQ-024 rst SHALL immediately force state IDLE, out_valid 0, result 0, flags 0, iteration counter 0, independent of clk.
REQ-025 rst during BUSY or HOLD SHALL discard the in-flight operation; no result SHALL appear afterwards.
REQ-026 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Package alu_pkg SHALL hold the op-code constants, the FSM state typedef, and flag bit indices.
REQ-028 Multiply SHALL be a sub-module alu_mul_iter (start, a, b -> done, product), WIDTH-parametrised, counter-driven shift-add.
REQ-029 Single-cycle ops SHALL be combinational logic feeding the output register; no other sub-modules.

Verification (WIDTH=16)
REQ-030 ADD a=0xFFFF b=0x0001 -> one cycle later out_valid=1, result=0x0000, flags neg0 zero1 carry1 ovf0.
REQ-031 SUB a=0x8000 b=0x0001 -> result=0x7FFF, ovf=1, carry=0, neg=0; SLT a=0xFFFF b=0x0001 -> result=0x0001.
REQ-032 MUL a=0x0012 b=0x0034 -> in_ready=0 for 16 cycles, out_valid at cycle 16, result=0x03A8.
REQ-033 SHL a=0x0001 b=15 -> 0x8000 (neg=1); b=16 -> 0x0000 (zero=1).
REQ-034 Backpressure: out_ready=0 for 5 cycles -> result/flags held, in_ready=0; then out_ready=1 with in_valid=1 (XOR 0x00FF,0x0F0F) -> next cycle result=0x0FF0.
REQ-035 rst pulse 5 cycles into MUL -> out_valid=0 immediately, no MUL result later; following AND 0xF0F0,0xFF00 -> 0xF000.
